// File: rtl/axis_ahb_bridge.sv
// AXI-Stream to AHB-Lite DMA-style bridge: stores inbound packets into AHB memory
// at consecutive word addresses and streams configured AHB regions back out.
module axis_ahb_bridge #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
) (
   input  logic                      clk_i,
   input  logic                      cke_i,
   input  logic                      arst_i,
   input  logic                      in_axis_tvalid_i,
   output logic                      in_axis_tready_o,
   input  logic [DATA_WIDTH-1:0]     in_axis_tdata_i,
   input  logic                      in_axis_tlast_i,
   output logic                      out_axis_tvalid_o,
   input  logic                      out_axis_tready_i,
   output logic [DATA_WIDTH-1:0]     out_axis_tdata_o,
   output logic                      out_axis_tlast_o,
   input  logic [ADDR_WIDTH-1:0]     config_in_addr_i,
   input  logic                      config_in_valid_i,
   output logic                      config_in_ready_o,
   input  logic [ADDR_WIDTH-1:0]     config_out_addr_i,
   input  logic [ADDR_WIDTH-1:0]     config_out_length_i,
   input  logic                      config_out_valid_i,
   output logic                      config_out_ready_o,
   output logic                      busy_o,
   output logic [ADDR_WIDTH-1:0]     m_ahb_addr_o,
   output logic [2:0]                m_ahb_burst_o,
   output logic                      m_ahb_mastlock_o,
   output logic [3:0]                m_ahb_prot_o,
   output logic [2:0]                m_ahb_size_o,
   output logic [1:0]                m_ahb_trans_o,
   output logic [DATA_WIDTH-1:0]     m_ahb_wdata_o,
   output logic [DATA_WIDTH/8-1:0]   m_ahb_wstrb_o,
   output logic                      m_ahb_write_o,
   input  logic [DATA_WIDTH-1:0]     m_ahb_rdata_i,
   input  logic                      m_ahb_readyout_i,
   input  logic                      m_ahb_resp_i,
   output logic                      m_ahb_sel_o
);

   localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(DATA_WIDTH / 8);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [2:0]            HSIZE     = 3'($clog2(DATA_WIDTH / 8));

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR_WAIT = 3'd1,
      ST_WR_ADDR = 3'd2,
      ST_WR_DATA = 3'd3,
      ST_RD_ADDR = 3'd4,
      ST_RD_DATA = 3'd5,
      ST_RD_OUT  = 3'd6
   } state_t;

   state_t                  state_r;
   state_t                  state_s;
   logic [ADDR_WIDTH-1:0]   addr_r;
   logic [ADDR_WIDTH-1:0]   len_r;
   logic [ADDR_WIDTH-1:0]   cnt_r;
   logic [DATA_WIDTH-1:0]   wdata_r;
   logic                    last_r;
   logic [DATA_WIDTH-1:0]   rdata_r;
   logic                    rd_last_s;
   logic                    unused_resp_s;

   // Bus errors complete like normal transfers, so HRESP carries no information here.
   assign unused_resp_s = m_ahb_resp_i;
   assign rd_last_s     = (cnt_r == (len_r - ADDR_ONE));

   // State register; reset is honoured only on enabled edges.
   always_ff @(posedge clk_i) begin
      if (!cke_i) begin
         state_r <= state_r;
      end else if (arst_i) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decode; a simultaneous write request takes priority over a read.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (config_in_valid_i) begin
               state_s = ST_WR_WAIT;
            end else if (config_out_valid_i && (config_out_length_i != ADDR_ZERO)) begin
               state_s = ST_RD_ADDR;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_WR_WAIT: state_s = in_axis_tvalid_i ? ST_WR_ADDR : ST_WR_WAIT;
         ST_WR_ADDR: state_s = m_ahb_readyout_i ? ST_WR_DATA : ST_WR_ADDR;
         ST_WR_DATA: begin
            if (m_ahb_readyout_i) begin
               state_s = last_r ? ST_IDLE : ST_WR_WAIT;
            end else begin
               state_s = ST_WR_DATA;
            end
         end
         ST_RD_ADDR: state_s = m_ahb_readyout_i ? ST_RD_DATA : ST_RD_ADDR;
         ST_RD_DATA: state_s = m_ahb_readyout_i ? ST_RD_OUT : ST_RD_DATA;
         ST_RD_OUT: begin
            if (out_axis_tready_i) begin
               state_s = rd_last_s ? ST_IDLE : ST_RD_ADDR;
            end else begin
               state_s = ST_RD_OUT;
            end
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // Job datapath: address, length/count and the single-word data holding registers.
   always_ff @(posedge clk_i) begin
      if (!cke_i) begin
         addr_r  <= addr_r;
      end else if (arst_i) begin
         addr_r  <= ADDR_ZERO;
         len_r   <= ADDR_ZERO;
         cnt_r   <= ADDR_ZERO;
         wdata_r <= {DATA_WIDTH{1'b0}};
         last_r  <= 1'b0;
         rdata_r <= {DATA_WIDTH{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (config_in_valid_i) begin
                  addr_r <= config_in_addr_i;
               end else if (config_out_valid_i) begin
                  addr_r <= config_out_addr_i;
                  len_r  <= config_out_length_i;
                  cnt_r  <= ADDR_ZERO;
               end else begin
                  addr_r <= addr_r;
               end
            end
            ST_WR_WAIT: begin
               if (in_axis_tvalid_i) begin
                  wdata_r <= in_axis_tdata_i;
                  last_r  <= in_axis_tlast_i;
               end else begin
                  wdata_r <= wdata_r;
               end
            end
            ST_WR_DATA: begin
               if (m_ahb_readyout_i && !last_r) begin
                  addr_r <= addr_r + ADDR_STEP;
               end else begin
                  addr_r <= addr_r;
               end
            end
            ST_RD_DATA: begin
               if (m_ahb_readyout_i) begin
                  rdata_r <= m_ahb_rdata_i;
               end else begin
                  rdata_r <= rdata_r;
               end
            end
            ST_RD_OUT: begin
               if (out_axis_tready_i) begin
                  cnt_r <= cnt_r + ADDR_ONE;
                  if (!rd_last_s) begin
                     addr_r <= addr_r + ADDR_STEP;
                  end else begin
                     addr_r <= addr_r;
                  end
               end else begin
                  cnt_r <= cnt_r;
               end
            end
            default: addr_r <= addr_r;
         endcase
      end
   end

   assign config_in_ready_o  = (state_r == ST_IDLE);
   assign config_out_ready_o = (state_r == ST_IDLE) & ~config_in_valid_i;
   assign busy_o             = (state_r != ST_IDLE);
   assign in_axis_tready_o   = (state_r == ST_WR_WAIT);
   assign out_axis_tvalid_o  = (state_r == ST_RD_OUT);
   assign out_axis_tlast_o   = (state_r == ST_RD_OUT) & rd_last_s;
   assign out_axis_tdata_o   = rdata_r;

   assign m_ahb_addr_o     = addr_r;
   assign m_ahb_burst_o    = 3'b000;
   assign m_ahb_mastlock_o = 1'b0;
   assign m_ahb_prot_o     = 4'b0011;
   assign m_ahb_size_o     = HSIZE;
   assign m_ahb_trans_o    = ((state_r == ST_WR_ADDR) || (state_r == ST_RD_ADDR)) ? 2'b10 : 2'b00;
   assign m_ahb_write_o    = (state_r == ST_WR_ADDR);
   assign m_ahb_wdata_o    = wdata_r;
   assign m_ahb_wstrb_o    = {(DATA_WIDTH/8){1'b1}};
   assign m_ahb_sel_o      = (state_r == ST_WR_ADDR) || (state_r == ST_WR_DATA) ||
                             (state_r == ST_RD_ADDR) || (state_r == ST_RD_DATA);

endmodule

// File: tb/tb_axis_ahb_bridge.sv
// Directed bench for axis_ahb_bridge with a 1 KB AHB RAM model and optional wait states.
module tb_axis_ahb_bridge;

   logic        clk_i = 1'b0;
   logic        cke_i, arst_i;
   logic        in_axis_tvalid_i, in_axis_tready_o, in_axis_tlast_i;
   logic [31:0] in_axis_tdata_i;
   logic        out_axis_tvalid_o, out_axis_tready_i, out_axis_tlast_o;
   logic [31:0] out_axis_tdata_o;
   logic [9:0]  config_in_addr_i, config_out_addr_i, config_out_length_i;
   logic        config_in_valid_i, config_in_ready_o, config_out_valid_i, config_out_ready_o;
   logic        busy_o;
   logic [9:0]  m_ahb_addr_o;
   logic [2:0]  m_ahb_burst_o, m_ahb_size_o;
   logic        m_ahb_mastlock_o, m_ahb_write_o, m_ahb_readyout_i, m_ahb_resp_i, m_ahb_sel_o;
   logic [3:0]  m_ahb_prot_o, m_ahb_wstrb_o;
   logic [1:0]  m_ahb_trans_o;
   logic [31:0] m_ahb_wdata_o, m_ahb_rdata_i;

   always #5 clk_i = ~clk_i;

   axis_ahb_bridge #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
      .clk_i(clk_i), .cke_i(cke_i), .arst_i(arst_i),
      .in_axis_tvalid_i(in_axis_tvalid_i), .in_axis_tready_o(in_axis_tready_o),
      .in_axis_tdata_i(in_axis_tdata_i), .in_axis_tlast_i(in_axis_tlast_i),
      .out_axis_tvalid_o(out_axis_tvalid_o), .out_axis_tready_i(out_axis_tready_i),
      .out_axis_tdata_o(out_axis_tdata_o), .out_axis_tlast_o(out_axis_tlast_o),
      .config_in_addr_i(config_in_addr_i), .config_in_valid_i(config_in_valid_i),
      .config_in_ready_o(config_in_ready_o), .config_out_addr_i(config_out_addr_i),
      .config_out_length_i(config_out_length_i), .config_out_valid_i(config_out_valid_i),
      .config_out_ready_o(config_out_ready_o), .busy_o(busy_o),
      .m_ahb_addr_o(m_ahb_addr_o), .m_ahb_burst_o(m_ahb_burst_o),
      .m_ahb_mastlock_o(m_ahb_mastlock_o), .m_ahb_prot_o(m_ahb_prot_o),
      .m_ahb_size_o(m_ahb_size_o), .m_ahb_trans_o(m_ahb_trans_o),
      .m_ahb_wdata_o(m_ahb_wdata_o), .m_ahb_wstrb_o(m_ahb_wstrb_o),
      .m_ahb_write_o(m_ahb_write_o), .m_ahb_rdata_i(m_ahb_rdata_i),
      .m_ahb_readyout_i(m_ahb_readyout_i), .m_ahb_resp_i(m_ahb_resp_i),
      .m_ahb_sel_o(m_ahb_sel_o)
   );

   logic [31:0] mem [0:255] = '{default: 32'h0};
   logic        rdy_r = 1'b1;
   logic [1:0]  wcnt_r = 2'd0;
   logic        wait_en = 1'b0;
   logic        pend_v = 1'b0, pend_w = 1'b0;
   logic [9:0]  pend_a = 10'd0;
   int          nonseq_cnt = 0;
   logic [10:0] addr_q [$];
   logic [31:0] exp_q [$];
   int          checks = 0, errors = 0;

   assign m_ahb_readyout_i = rdy_r;
   assign m_ahb_rdata_i    = mem[pend_a[9:2]];
   assign m_ahb_resp_i     = 1'b0;

   // AHB RAM slave: address phase captured on HREADY, write data stored in the data phase.
   always @(posedge clk_i) begin
      if (m_ahb_readyout_i) begin
         if (pend_v && pend_w) mem[pend_a[9:2]] <= m_ahb_wdata_o;
         pend_v <= m_ahb_sel_o && (m_ahb_trans_o == 2'b10);
         pend_a <= m_ahb_addr_o;
         pend_w <= m_ahb_write_o;
         if (m_ahb_sel_o && (m_ahb_trans_o == 2'b10)) begin
            nonseq_cnt <= nonseq_cnt + 1;
            addr_q.push_back({m_ahb_write_o, m_ahb_addr_o});
         end
      end
      // two wait cycles at the start of every phase when enabled
      if (!wait_en) begin
         rdy_r <= 1'b1; wcnt_r <= 2'd0;
      end else if (!m_ahb_sel_o || rdy_r) begin
         rdy_r <= 1'b0; wcnt_r <= 2'd1;
      end else if (wcnt_r == 2'd2) begin
         rdy_r <= 1'b1;
      end else begin
         wcnt_r <= wcnt_r + 2'd1;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic start_wr(input logic [9:0] a);
      chk("cin_ready_pre", config_in_ready_o, 1);
      config_in_addr_i = a; config_in_valid_i = 1'b1;
      @(negedge clk_i);
      config_in_valid_i = 1'b0;
   endtask

   task automatic start_rd(input logic [9:0] a, input logic [9:0] len);
      chk("cout_ready_pre", config_out_ready_o, 1);
      config_out_addr_i = a; config_out_length_i = len; config_out_valid_i = 1'b1;
      @(negedge clk_i);
      config_out_valid_i = 1'b0;
   endtask

   task automatic send_beat(input logic [31:0] d, input logic last);
      int n = 0;
      in_axis_tvalid_i = 1'b1; in_axis_tdata_i = d; in_axis_tlast_i = last;
      while (!in_axis_tready_o && n < 50) begin
         @(negedge clk_i); n++;
      end
      if (n >= 50) chk("wr_beat_timeout", n, 0);
      @(negedge clk_i);
      in_axis_tvalid_i = 1'b0; in_axis_tlast_i = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      while (busy_o && n < 50) begin
         @(negedge clk_i); n++;
      end
      chk(nm, busy_o, 0);
   endtask

   task automatic recv(input int n, input bit tog, input string nm);
      int i = 0;
      int guard = 0;
      bit held = 1'b0;
      logic [33:0] hv = 34'd0;
      while (i < n && guard < 5000) begin
         if (held) chk({nm, "_hold"}, {out_axis_tvalid_o, out_axis_tlast_o, out_axis_tdata_o}, hv);
         out_axis_tready_i = tog ? guard[0] : 1'b1;
         if (out_axis_tvalid_o) begin
            if (out_axis_tready_i) begin
               chk({nm, "_data"}, out_axis_tdata_o, exp_q[i]);
               chk({nm, "_last"}, out_axis_tlast_o, (i == n - 1));
               i++; held = 1'b0;
            end else begin
               held = 1'b1; hv = {out_axis_tvalid_o, out_axis_tlast_o, out_axis_tdata_o};
            end
         end else begin
            held = 1'b0;
         end
         @(negedge clk_i); guard++;
      end
      out_axis_tready_i = 1'b0;
      chk({nm, "_beats"}, i, n);
   endtask

   typedef struct {
      logic [9:0]  addr;
      logic [31:0] d0;
      logic [31:0] d1;
      logic [9:0]  a0;
      logic [9:0]  a1;
   } job_t;

   typedef struct {
      logic civ;
      logic cov;
      logic cin_rdy;
      logic cout_rdy;
   } dec_t;

   initial begin
      job_t jobs [4];
      dec_t decs [4];
      int   n0;
      jobs[0] = '{10'h010, 32'hDEADBEEF, 32'h12345678, 10'h010, 10'h014};
      jobs[1] = '{10'h3FC, 32'hA5A5A5A5, 32'h5A5A5A5A, 10'h3FC, 10'h000};
      jobs[2] = '{10'h3FE, 32'h00000001, 32'hFFFFFFFF, 10'h3FE, 10'h002};
      jobs[3] = '{10'h102, 32'hCAFEF00D, 32'h0BADC0DE, 10'h102, 10'h106};
      decs[0] = '{1'b0, 1'b0, 1'b1, 1'b1};
      decs[1] = '{1'b1, 1'b0, 1'b1, 1'b0};
      decs[2] = '{1'b0, 1'b1, 1'b1, 1'b1};
      decs[3] = '{1'b1, 1'b1, 1'b1, 1'b0};

      cke_i = 1'b1; arst_i = 1'b1;
      in_axis_tvalid_i = 1'b0; in_axis_tdata_i = 32'd0; in_axis_tlast_i = 1'b0;
      out_axis_tready_i = 1'b0;
      config_in_addr_i = 10'd0; config_in_valid_i = 1'b0;
      config_out_addr_i = 10'd0; config_out_length_i = 10'd0; config_out_valid_i = 1'b0;
      repeat (3) @(negedge clk_i);

      // reset state
      chk("rst_busy", busy_o, 0);
      chk("rst_cin_ready", config_in_ready_o, 1);
      chk("rst_cout_ready", config_out_ready_o, 1);
      chk("rst_trans", m_ahb_trans_o, 0);
      chk("rst_sel", m_ahb_sel_o, 0);
      chk("rst_tready", in_axis_tready_o, 0);
      chk("rst_tvalid", out_axis_tvalid_o, 0);
      chk("rst_tdata", out_axis_tdata_o, 0);
      chk("rst_haddr", m_ahb_addr_o, 0);
      chk("const_fields", {m_ahb_burst_o, m_ahb_mastlock_o, m_ahb_prot_o, m_ahb_size_o, m_ahb_wstrb_o},
          {3'b000, 1'b0, 4'b0011, 3'b010, 4'b1111});
      config_in_valid_i = 1'b1; #1;
      chk("rst_cout_ready_civ", config_out_ready_o, 0);
      config_in_valid_i = 1'b0;
      arst_i = 1'b0;
      @(negedge clk_i);

      // IDLE handshake-ready decode table
      for (int k = 0; k < 4; k++) begin
         config_in_valid_i = decs[k].civ; config_out_valid_i = decs[k].cov; #1;
         chk("dec_cin_ready", config_in_ready_o, decs[k].cin_rdy);
         chk("dec_cout_ready", config_out_ready_o, decs[k].cout_rdy);
         config_in_valid_i = 1'b0; config_out_valid_i = 1'b0;
      end

      // clock enable low holds IDLE despite a request
      cke_i = 1'b0; config_in_valid_i = 1'b1;
      repeat (2) @(negedge clk_i);
      chk("cke_hold_busy", busy_o, 0);
      config_in_valid_i = 1'b0; cke_i = 1'b1;
      @(negedge clk_i);

      // 256-word write packet starting at address 0
      addr_q.delete();
      start_wr(10'h000);
      for (int i = 0; i < 256; i++) send_beat(32'(i), (i == 255));
      wait_idle("wr256_idle");
      chk("wr256_cin_ready", config_in_ready_o, 1);
      chk("wr256_ntrans", addr_q.size(), 256);
      for (int i = 0; i < 256; i++) begin
         if (i < addr_q.size()) chk("wr256_addr", addr_q[i], {1'b1, 10'(i * 4)});
         chk("wr256_mem", mem[i], 32'(i));
      end

      // read the same 256 words back
      exp_q.delete();
      for (int i = 0; i < 256; i++) exp_q.push_back(32'(i));
      start_rd(10'h000, 10'd256);
      recv(256, 1'b0, "rd256");
      wait_idle("rd256_idle");

      // zero-length read does nothing
      n0 = nonseq_cnt;
      start_rd(10'h010, 10'd0);
      repeat (3) begin
         chk("len0_busy", busy_o, 0);
         chk("len0_tvalid", out_axis_tvalid_o, 0);
         chk("len0_cout_ready", config_out_ready_o, 1);
         @(negedge clk_i);
      end
      chk("len0_ntrans", nonseq_cnt - n0, 0);

      // wait states on every phase plus a toggling consumer
      wait_en = 1'b1;
      start_wr(10'h200);
      for (int i = 0; i < 4; i++) send_beat(32'h10000000 + 32'(i) * 32'h01111111, (i == 3));
      wait_idle("ws_wr_idle");
      exp_q.delete();
      for (int i = 0; i < 4; i++) begin
         chk("ws_mem", mem[128 + i], 32'h10000000 + 32'(i) * 32'h01111111);
         exp_q.push_back(32'h10000000 + 32'(i) * 32'h01111111);
      end
      start_rd(10'h200, 10'd4);
      recv(4, 1'b1, "ws_rd");
      wait_idle("ws_rd_idle");
      wait_en = 1'b0;
      @(negedge clk_i);

      // simultaneous requests: the write job wins
      n0 = nonseq_cnt;
      config_in_addr_i = 10'h300; config_in_valid_i = 1'b1;
      config_out_addr_i = 10'h000; config_out_length_i = 10'd4; config_out_valid_i = 1'b1; #1;
      chk("both_cout_ready", config_out_ready_o, 0);
      chk("both_cin_ready", config_in_ready_o, 1);
      @(negedge clk_i);
      config_in_valid_i = 1'b0; config_out_valid_i = 1'b0;
      chk("both_wr_wait", in_axis_tready_o, 1);
      send_beat(32'h0000BEEF, 1'b1);
      wait_idle("both_idle");
      chk("both_ntrans", nonseq_cnt - n0, 1);
      chk("both_mem", mem[192], 32'h0000BEEF);
      chk("both_tvalid", out_axis_tvalid_o, 0);

      // two-word jobs including address wrap; low address bits preserved
      for (int k = 0; k < 4; k++) begin
         addr_q.delete();
         start_wr(jobs[k].addr);
         send_beat(jobs[k].d0, 1'b0);
         send_beat(jobs[k].d1, 1'b1);
         wait_idle("job_wr_idle");
         exp_q.delete();
         exp_q.push_back(jobs[k].d0);
         exp_q.push_back(jobs[k].d1);
         start_rd(jobs[k].addr, 10'd2);
         recv(2, 1'b0, "job_rd");
         wait_idle("job_rd_idle");
         chk("job_ntrans", addr_q.size(), 4);
         if (addr_q.size() == 4) begin
            chk("job_wa0", addr_q[0], {1'b1, jobs[k].a0});
            chk("job_wa1", addr_q[1], {1'b1, jobs[k].a1});
            chk("job_ra0", addr_q[2], {1'b0, jobs[k].a0});
            chk("job_ra1", addr_q[3], {1'b0, jobs[k].a1});
         end
      end

      // reset pulse in the middle of a write packet
      start_wr(10'h040);
      for (int i = 0; i < 3; i++) send_beat(32'h55000000 + 32'(i), 1'b0);
      arst_i = 1'b1;
      @(negedge clk_i);
      arst_i = 1'b0;
      chk("mid_rst_trans", m_ahb_trans_o, 0);
      chk("mid_rst_tready", in_axis_tready_o, 0);
      chk("mid_rst_busy", busy_o, 0);
      chk("mid_rst_cin_ready", config_in_ready_o, 1);
      repeat (2) @(negedge clk_i);
      start_wr(10'h080);
      send_beat(32'h00000077, 1'b1);
      wait_idle("post_rst_wr_idle");
      chk("post_rst_mem", mem[32], 32'h00000077);
      exp_q.delete();
      exp_q.push_back(32'h00000077);
      start_rd(10'h080, 10'd1);
      recv(1, 1'b0, "post_rst_rd");
      wait_idle("post_rst_rd_idle");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
